// File: rtl/seg_pkg.sv
// seg_pkg: shared glyph table, blanking constants and scan FSM states
package seg_pkg;
  localparam logic [6:0] GLYPH [16] = '{
    7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
    7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
    7'b000_0000, 7'b000_0100, 7'b000_1000, 7'b110_0000,
    7'b011_0001, 7'b100_0010, 7'b011_0000, 7'b011_1000
  };
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  typedef enum logic {BLANK, SHOW} state_t;
endpackage

// File: rtl/hex7seg_decode.sv
// hex7seg_decode: hex nibble to active-low {a..g} glyph
module hex7seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] glyph_o
);
  assign glyph_o = GLYPH[nib_i];
endmodule

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: 4-digit 7-segment scanner with inter-digit blanking and frame-aligned value loading
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int REFRESH_CNT = 100_000,
  parameter int BLANK_CNT   = 1_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [3:0]  digit_en,
  input  logic        lz_blank,
  output logic [6:0]  seg,
  output logic [3:0]  digit,
  output logic        frame_done
);
  localparam int MAX_CNT = REFRESH_CNT > BLANK_CNT ? REFRESH_CNT : BLANK_CNT;
  localparam int TW = MAX_CNT > 1 ? $clog2(MAX_CNT) : 1;
  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   disp_q, disp_d, pend_q, pend_d;
  logic          pfull_q, pfull_d, fd_q;
  logic [6:0]    seg_q, seg_d, glyph;
  logic [3:0]    digit_q, digit_d;
  logic          done, frame_start, copy, acc, lit;
  hex7seg_decode u_dec (
    .nib_i  (disp_q[{idx_q, 2'b00} +: 4]),
    .glyph_o(glyph)
  );
  always_comb begin
    done        = timer_q == TW'(state_q == BLANK ? BLANK_CNT - 1 : REFRESH_CNT - 1);
    frame_start = done && state_q == SHOW && idx_q == 2'd3;
    state_d     = done ? (state_q == BLANK ? SHOW : BLANK) : state_q;
    idx_d       = idx_q + 2'(done && state_q == SHOW);
    timer_d     = done ? '0 : timer_q + TW'(1);
    lit         = state_q == SHOW && digit_en[idx_q] &&
                  !(lz_blank && idx_q != 2'd0 && (disp_q >> {idx_q, 2'b00}) == 16'h0);
    digit_d     = lit ? ~(4'b0001 << idx_q) : ANODE_OFF;
    seg_d       = lit ? glyph : SEG_BLANK;
    copy        = frame_start && pfull_q;
    acc         = load_valid && !pfull_q;
    disp_d      = copy ? pend_q : disp_q;
    pend_d      = acc ? value_in : pend_q;
    pfull_d     = copy ? 1'b0 : (acc ? 1'b1 : pfull_q);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BLANK;
      idx_q   <= 2'd0;
      timer_q <= '0;
      disp_q  <= 16'h0000;
      pend_q  <= 16'h0000;
      pfull_q <= 1'b0;
      seg_q   <= SEG_BLANK;
      digit_q <= ANODE_OFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pfull_q <= pfull_d;
      seg_q   <= seg_d;
      digit_q <= digit_d;
      fd_q    <= frame_start;
    end
  end
  assign load_ready = !pfull_q;
  assign seg        = seg_q;
  assign digit      = digit_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: directed scan/load/blanking checks against a cycle model with a pending-value scoreboard
module tb_seg_scan_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [6:0]  seg;
  logic [3:0]  digit;
  logic        frame_done;
  int          n_assert = 0;
  int          n_fail = 0;
  int          k;
  logic [15:0] mdisp;
  logic [15:0] q[$];
  logic [3:0]  e_digit;
  logic [6:0]  e_seg;
  logic        e_fd, e_ready;
  seg_scan_controller #(.REFRESH_CNT(4), .BLANK_CNT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .value_in  (value_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .digit_en  (digit_en),
    .lz_blank  (lz_blank),
    .seg       (seg),
    .digit     (digit),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b000_0001;
      4'h1: return 7'b100_1111;
      4'h2: return 7'b001_0010;
      4'h3: return 7'b000_0110;
      4'h4: return 7'b100_1100;
      4'h5: return 7'b010_0100;
      4'h6: return 7'b010_0000;
      4'h7: return 7'b000_1111;
      4'h8: return 7'b000_0000;
      4'h9: return 7'b000_0100;
      4'hA: return 7'b000_1000;
      4'hB: return 7'b110_0000;
      4'hC: return 7'b011_0001;
      4'hD: return 7'b100_0010;
      4'hE: return 7'b011_0000;
      default: return 7'b011_1000;
    endcase
  endfunction
  function automatic void chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at k=%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endfunction
  function automatic void check_all();
    chk("digit", 16'(digit), 16'(e_digit));
    chk("seg", 16'(seg), 16'(e_seg));
    chk("frame_done", 16'(frame_done), 16'(e_fd));
    chk("load_ready", 16'(load_ready), 16'(e_ready));
  endfunction
  function automatic void model_reset();
    k = 0;
    q.delete();
    mdisp = 16'h0000;
    e_digit = 4'hF;
    e_seg = 7'h7F;
    e_fd = 1'b0;
    e_ready = 1'b1;
  endfunction
  // Position k in the 20-cycle frame: slot k/5, first cycle of each slot blank; outputs lag by one cycle.
  function automatic void step();
    int s;
    logic fs, sup;
    s = (k % 20) / 5;
    fs = ((k + 1) % 20) == 0;
    sup = !digit_en[s] || (lz_blank && s > 0 && (mdisp >> (4 * s)) == 16'h0);
    if (k % 5 == 0 || sup) begin
      e_digit = 4'hF;
      e_seg = 7'h7F;
    end else begin
      e_digit = 4'hF & ~(4'h1 << s);
      e_seg = glyph(mdisp[4 * s +: 4]);
    end
    e_fd = fs;
    if (fs && q.size() > 0) mdisp = q.pop_front();
    else if (load_valid && q.size() == 0) q.push_back(value_in);
    e_ready = q.size() == 0;
    k++;
  endfunction
  task automatic tick();
    @(posedge clk);
    if (rst) step();
    @(negedge clk);
    check_all();
  endtask
  task automatic load(input logic [15:0] v);
    value_in = v;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    value_in = 16'h0000;
  endtask
  initial begin
    rst = 1'b0;
    value_in = 16'h0000;
    load_valid = 1'b0;
    digit_en = 4'hF;
    lz_blank = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b1;
    repeat (45) tick();
    load(16'h12AF);
    repeat (45) tick();
    lz_blank = 1'b1;
    load(16'h0050);
    repeat (45) tick();
    lz_blank = 1'b0;
    digit_en = 4'b0101;
    load(16'h8888);
    repeat (45) tick();
    digit_en = 4'hF;
    while ((k + 1) % 20 != 0) tick();
    load(16'h1234);
    value_in = 16'h5678;
    load_valid = 1'b1;
    repeat (3) tick();
    load_valid = 1'b0;
    value_in = 16'h0000;
    repeat (50) tick();
    while (k % 20 != 2) tick();
    load(16'h9999);
    while (k % 20 != 12) tick();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (3) tick();
    rst = 1'b1;
    repeat (45) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_controller.md
SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

Interface
REQ-001 Parameter REFRESH_CNT, default 100_000, gives the clk cycles each digit is lit (1 ms at 100 MHz).
REQ-002 Parameter BLANK_CNT, default 1_000, gives the clk cycles with all anodes off before each digit, for ghost suppression; legal range is >= 1.
REQ-003 Port clk, input, 1 bit: the sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port value_in, input, 16 bits: four hex nibbles; [3:0] is digit 0 (ones) and [15:12] is digit 3 (thousands).
REQ-006 Port load_valid, input, 1 bit: value_in is offered for display.
REQ-007 Port load_ready, output, 1 bit: the pending slot is empty; a transfer occurs when load_valid and load_ready are both high at a clk edge.
REQ-008 Port digit_en, input, 4 bits: per-digit enable; bit i = 0 keeps the anode of digit i off.
REQ-009 Port lz_blank, input, 1 bit: enables leading-zero blanking.
REQ-010 Port seg, output, 7 bits, active-low: {a,b,c,d,e,f,g} with a in bit 6; uses the team's hex glyph set (0 = 7'b000_0001, 8 = 7'b000_0000, F = 7'b011_1000).
REQ-011 Port digit, output, 4 bits, active-low one-hot anode select; bit i drives digit i.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse at the end of each 4-digit frame.

Function
REQ-013 FSM states: BLANK and SHOW. A 2-bit index idx selects the current digit.
- BLANK lasts exactly BLANK_CNT cycles, then moves to SHOW.
- SHOW lasts exactly REFRESH_CNT cycles, then moves to BLANK with idx+1; idx wraps from 3 to 0.
REQ-014 Frame period is fixed at 4*(BLANK_CNT+REFRESH_CNT) cycles, regardless of digit_en and lz_blank.
REQ-015 In BLANK, digit = 4'b1111 and seg = 7'b111_1111.
REQ-016 In SHOW, digit has bit idx low and the other bits high; seg is the glyph of display nibble idx.
- Exception: the digit is suppressed (digit = 4'b1111, seg = 7'b111_1111) when digit_en[idx] = 0, or when it is leading-zero blanked.
REQ-017 Leading-zero blanking: when lz_blank = 1, digit i > 0 is suppressed if display nibbles i..3 are all zero; digit 0 is never leading-zero blanked.
REQ-018 seg and digit are registered and change only at state/idx transitions (one-cycle pipeline from FSM state).
REQ-019 Load path:
- An accepted value_in is stored in the pending register; load_ready drops the next cycle.
- On the cycle the FSM enters BLANK with idx = 0 (frame start), a full pending register is copied to the display register, the slot is cleared, and load_ready rises the following cycle.
REQ-020 The display register never changes mid-frame; all four digits of a frame show the same value.
REQ-021 Simultaneous accept and frame start with pending empty: the value goes to pending and is displayed from the next frame start, not the current one.
REQ-022 Further load_valid while pending is full is ignored; value_in is not sampled.
REQ-023 frame_done pulses high for one cycle on the SHOW to BLANK transition with idx 3 to 0, coincident with the display-register copy.
REQ-024 Timer width is clog2(max(REFRESH_CNT, BLANK_CNT)); the counter counts 0..N-1 and resets to 0 on every state change.

Reset
REQ-025 While rst = 0: state = BLANK, idx = 0, timer = 0, display register = 16'h0000, pending empty, load_ready = 1, digit = 4'b1111, seg = 7'b111_1111, frame_done = 0.
REQ-026 Reset asserted mid-operation aborts immediately and discards any pending value.
REQ-027 After release, the first frame starts with BLANK for digit 0.

Structure
REQ-028 A shared package seg_pkg holds:
- the 16 glyph constants and the blank constant 7'b111_1111;
- the anode-off constant 4'b1111;
- the FSM state enum.
REQ-029 One combinational sub-module, hex7seg_decode (4-bit nibble to 7-bit glyph), is instantiated once and fed the nibble selected by idx.

Verification
All scenarios use REFRESH_CNT = 4 and BLANK_CNT = 1 (frame = 20 cycles).
REQ-030 Reset release with no load: digit sequence 1111, 1110 (x4), 1111, 1101 (x4), ...; seg = 7'b000_0001 on every lit digit; frame_done every 20 cycles.
REQ-031 Load 16'h12AF mid-frame: load_ready drops the next cycle; old value stays until frame_done; next frame shows F, A, 2, 1 on digits 0..3; load_ready re-rises the cycle after frame start.
REQ-032 lz_blank = 1 with value 16'h0050: digits 3 and 2 stay 1111 during their SHOW slots; digit 1 shows 5; digit 0 shows 0; the frame is still 20 cycles.
REQ-033 digit_en = 4'b0101 with value 16'h8888: only anodes 1110 and 1011 are ever driven low; seg = 7'b000_0000 only in those slots.
REQ-034 Load accepted on the frame-start cycle, then a second load_valid while pending is full: the first value is displayed one frame later; the second is ignored with load_ready low.
REQ-035 rst pulsed low during SHOW of idx 2 with pending full: outputs go to reset values asynchronously; the pending value is never displayed.
